// File: rtl/psr_cond_unit_if.sv
// Bus between the ALU/branch controller and the PSR + condition evaluator.
// The master drives flags, writes and condition requests; the slave returns PSR state and results.
interface psr_cond_unit_if #(
    parameter int WIDTH_DATA = 16,
    parameter int WIDTH_COND = 4
);
    logic                  alu_carry;
    logic                  alu_low;
    logic                  alu_over;
    logic                  alu_neg;
    logic                  alu_zero;
    logic [4:0]            flag_we;
    logic                  psr_we;
    logic [WIDTH_DATA-1:0] psr_wdata;
    logic [WIDTH_DATA-1:0] psr_rdata;
    logic                  carry_flag;
    logic                  cond_req;
    logic [WIDTH_COND-1:0] cond_code;
    logic                  cond_valid;
    logic                  cond_taken;

    modport master (
        output alu_carry, alu_low, alu_over, alu_neg, alu_zero,
        output flag_we, psr_we, psr_wdata, cond_req, cond_code,
        input  psr_rdata, carry_flag, cond_valid, cond_taken
    );

    modport slave (
        input  alu_carry, alu_low, alu_over, alu_neg, alu_zero,
        input  flag_we, psr_we, psr_wdata, cond_req, cond_code,
        output psr_rdata, carry_flag, cond_valid, cond_taken
    );
endinterface

// File: rtl/psr_cond_unit.sv
// Processor status register (C/L/F/N/Z) with carry feedback and a one-cycle
// registered branch-condition evaluator.
module psr_cond_unit #(
    parameter int WIDTH_DATA = 16,
    parameter int WIDTH_COND = 4,
    parameter bit BYPASS     = 1'b0
) (
    input logic           clk,
    input logic           rst_n,
    psr_cond_unit_if.slave bus
);
    // Flag vector order matches flag_we: {C,L,F,N,Z}
    localparam int IDX_C = 4;
    localparam int IDX_L = 3;
    localparam int IDX_F = 2;
    localparam int IDX_N = 1;
    localparam int IDX_Z = 0;

    logic [4:0]            flags_q, flags_d;
    logic [4:0]            alu_flags;
    logic [4:0]            eval_flags;
    logic                  cond_valid_q, cond_valid_d;
    logic                  cond_taken_q, cond_taken_d;
    logic                  result;
    logic [WIDTH_COND-1:0] code_w;
    logic [3:0]            code;
    logic [WIDTH_DATA-1:0] rdata;

    assign alu_flags = {bus.alu_carry, bus.alu_low, bus.alu_over, bus.alu_neg, bus.alu_zero};
    assign code_w    = bus.cond_code;
    assign code      = code_w[3:0];

    always_comb begin
        flags_d = flags_q;
        if (bus.psr_we) begin
            flags_d = {bus.psr_wdata[0], bus.psr_wdata[2], bus.psr_wdata[5],
                       bus.psr_wdata[7], bus.psr_wdata[6]};
        end else begin
            for (int i = 0; i < 5; i++) begin
                if (bus.flag_we[i]) flags_d[i] = alu_flags[i];
            end
        end
    end

    // BYPASS lets a request see flag writes landing on the same edge
    assign eval_flags = BYPASS ? flags_d : flags_q;

    always_comb begin
        result = 1'b0;
        case (code)
            4'd0:  result =  eval_flags[IDX_Z];
            4'd1:  result = !eval_flags[IDX_Z];
            4'd2:  result =  eval_flags[IDX_C];
            4'd3:  result = !eval_flags[IDX_C];
            4'd4:  result =  eval_flags[IDX_L];
            4'd5:  result = !eval_flags[IDX_L];
            4'd6:  result =  eval_flags[IDX_N];
            4'd7:  result = !eval_flags[IDX_N];
            4'd8:  result =  eval_flags[IDX_F];
            4'd9:  result = !eval_flags[IDX_F];
            4'd10: result = !eval_flags[IDX_L] && !eval_flags[IDX_Z];
            4'd11: result =  eval_flags[IDX_L] ||  eval_flags[IDX_Z];
            4'd12: result = !eval_flags[IDX_N] && !eval_flags[IDX_Z];
            4'd13: result =  eval_flags[IDX_N] ||  eval_flags[IDX_Z];
            4'd14: result = 1'b1;
            4'd15: result = 1'b0;
            default: result = 1'b0;
        endcase
    end

    always_comb begin
        cond_valid_d = bus.cond_req;
        cond_taken_d = bus.cond_req && result;
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            flags_q      <= '0;
            cond_valid_q <= 1'b0;
            cond_taken_q <= 1'b0;
        end else begin
            flags_q      <= flags_d;
            cond_valid_q <= cond_valid_d;
            cond_taken_q <= cond_taken_d;
        end
    end

    always_comb begin
        rdata    = '0;
        rdata[0] = flags_q[IDX_C];
        rdata[2] = flags_q[IDX_L];
        rdata[5] = flags_q[IDX_F];
        rdata[6] = flags_q[IDX_Z];
        rdata[7] = flags_q[IDX_N];
    end

    assign bus.psr_rdata  = rdata;
    assign bus.carry_flag = flags_q[IDX_C];
    assign bus.cond_valid = cond_valid_q;
    assign bus.cond_taken = cond_taken_q;
endmodule

// File: tb/tb_psr_cond_unit.sv
// Directed bench for psr_cond_unit: one instance without and one with BYPASS,
// driven identically so same-edge update behaviour can be compared.
module tb_psr_cond_unit;
    logic clk;
    logic rst_n;

    logic [4:0]  alu_flags;
    logic [4:0]  flag_we;
    logic        psr_we;
    logic [15:0] psr_wdata;
    logic        cond_req;
    logic [3:0]  cond_code;

    int checks;
    int failures;

    psr_cond_unit_if #(.WIDTH_DATA(16), .WIDTH_COND(4)) if0 ();
    psr_cond_unit_if #(.WIDTH_DATA(16), .WIDTH_COND(4)) if1 ();

    assign {if0.alu_carry, if0.alu_low, if0.alu_over, if0.alu_neg, if0.alu_zero} = alu_flags;
    assign {if1.alu_carry, if1.alu_low, if1.alu_over, if1.alu_neg, if1.alu_zero} = alu_flags;
    assign if0.flag_we   = flag_we;
    assign if1.flag_we   = flag_we;
    assign if0.psr_we    = psr_we;
    assign if1.psr_we    = psr_we;
    assign if0.psr_wdata = psr_wdata;
    assign if1.psr_wdata = psr_wdata;
    assign if0.cond_req  = cond_req;
    assign if1.cond_req  = cond_req;
    assign if0.cond_code = cond_code;
    assign if1.cond_code = cond_code;

    psr_cond_unit #(.WIDTH_DATA(16), .WIDTH_COND(4), .BYPASS(1'b0)) dut0 (
        .clk   (clk),
        .rst_n (rst_n),
        .bus   (if0)
    );

    psr_cond_unit #(.WIDTH_DATA(16), .WIDTH_COND(4), .BYPASS(1'b1)) dut1 (
        .clk   (clk),
        .rst_n (rst_n),
        .bus   (if1)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    typedef struct {
        logic [4:0]  we;
        logic        pwe;
        logic [15:0] wdata;
        logic [4:0]  alu;
        logic        req;
        logic [3:0]  code;
        logic [15:0] exp_rdata;
        logic        exp_valid;
        logic        exp_t0;
        logic        exp_t1;
    } vec_t;

    vec_t vecs[$];
    logic sweep_exp[16];

    task automatic checkOutput(input string name, input logic [15:0] actual, input logic [15:0] expected);
        checks++;
        if (actual !== expected) begin
            failures++;
            $display("[TB] FAIL %s: got 0x%0h, expected 0x%0h", name, actual, expected);
        end
    endtask

    // Drive one cycle of inputs, clock it in, then settle just past the edge
    task automatic applyStimulus(input logic [4:0] we, input logic pwe, input logic [15:0] wdata,
                                 input logic [4:0] alu, input logic req, input logic [3:0] code);
        flag_we   = we;
        psr_we    = pwe;
        psr_wdata = wdata;
        alu_flags = alu;
        cond_req  = req;
        cond_code = code;
        @(posedge clk);
        #1;
    endtask

    task automatic checkBoth(input string name, input logic [15:0] exp_rdata,
                             input logic exp_valid, input logic exp_t0, input logic exp_t1);
        checkOutput({name, " rdata0"}, if0.psr_rdata, exp_rdata);
        checkOutput({name, " rdata1"}, if1.psr_rdata, exp_rdata);
        checkOutput({name, " carry0"}, {15'd0, if0.carry_flag}, {15'd0, exp_rdata[0]});
        checkOutput({name, " valid0"}, {15'd0, if0.cond_valid}, {15'd0, exp_valid});
        checkOutput({name, " valid1"}, {15'd0, if1.cond_valid}, {15'd0, exp_valid});
        checkOutput({name, " taken0"}, {15'd0, if0.cond_taken}, {15'd0, exp_t0});
        checkOutput({name, " taken1"}, {15'd0, if1.cond_taken}, {15'd0, exp_t1});
    endtask

    initial begin
        #50000;
        $display("[TB] FAIL watchdog: simulation did not finish, time=%0t", $time);
        $fatal(1, "[TB] watchdog expired");
    end

    initial begin
        checks    = 0;
        failures  = 0;
        rst_n     = 1'b0;
        flag_we   = '0;
        psr_we    = 1'b0;
        psr_wdata = '0;
        alu_flags = '0;
        cond_req  = 1'b0;
        cond_code = '0;

        //            we        pwe   wdata     alu       req   code   rdata     v     t0    t1
        vecs.push_back('{5'h1F,   1'b0, 16'h0000, 5'h1F,   1'b0, 4'd0,  16'h00E5, 1'b0, 1'b0, 1'b0});
        vecs.push_back('{5'h01,   1'b0, 16'h0000, 5'h1E,   1'b1, 4'd0,  16'h00A5, 1'b1, 1'b1, 1'b0});
        vecs.push_back('{5'h1F,   1'b1, 16'hFFFF, 5'h00,   1'b1, 4'd2,  16'h00E5, 1'b1, 1'b1, 1'b1});
        vecs.push_back('{5'h00,   1'b1, 16'hFF1A, 5'h00,   1'b1, 4'd14, 16'h0000, 1'b1, 1'b1, 1'b1});
        vecs.push_back('{5'h00,   1'b1, 16'h0080, 5'h00,   1'b1, 4'd6,  16'h0080, 1'b1, 1'b0, 1'b1});
        vecs.push_back('{5'h10,   1'b0, 16'h0000, 5'h1F,   1'b1, 4'd13, 16'h0081, 1'b1, 1'b1, 1'b1});
        vecs.push_back('{5'h00,   1'b0, 16'h0000, 5'h1F,   1'b0, 4'd15, 16'h0081, 1'b0, 1'b0, 1'b0});
        vecs.push_back('{5'h00,   1'b1, 16'h0000, 5'h1F,   1'b1, 4'd3,  16'h0000, 1'b1, 1'b0, 1'b1});
        vecs.push_back('{5'h01,   1'b0, 16'h0000, 5'h01,   1'b1, 4'd0,  16'h0040, 1'b1, 1'b0, 1'b1});
        vecs.push_back('{5'h08,   1'b0, 16'h0000, 5'h08,   1'b1, 4'd4,  16'h0044, 1'b1, 1'b0, 1'b1});
        vecs.push_back('{5'h04,   1'b0, 16'h0000, 5'h04,   1'b1, 4'd8,  16'h0064, 1'b1, 1'b0, 1'b1});
        vecs.push_back('{5'h02,   1'b0, 16'h0000, 5'h00,   1'b1, 4'd12, 16'h0064, 1'b1, 1'b0, 1'b0});

        sweep_exp = '{1'b1, 1'b0, 1'b0, 1'b1, 1'b0, 1'b1, 1'b0, 1'b1,
                      1'b0, 1'b1, 1'b0, 1'b1, 1'b0, 1'b1, 1'b1, 1'b0};

        #12;
        checkBoth("reset", 16'h0000, 1'b0, 1'b0, 1'b0);
        rst_n = 1'b1;
        #1;

        for (int i = 0; i < vecs.size(); i++) begin
            applyStimulus(vecs[i].we, vecs[i].pwe, vecs[i].wdata, vecs[i].alu, vecs[i].req, vecs[i].code);
            checkBoth($sformatf("vec%0d", i), vecs[i].exp_rdata, vecs[i].exp_valid,
                      vecs[i].exp_t0, vecs[i].exp_t1);
        end

        applyStimulus(5'h00, 1'b1, 16'h0040, 5'h1F, 1'b0, 4'd0);
        checkBoth("sweep_setup", 16'h0040, 1'b0, 1'b0, 1'b0);
        for (int c = 0; c < 16; c++) begin
            applyStimulus(5'h00, 1'b0, 16'h0000, 5'h1F, 1'b1, 4'(c));
            checkBoth($sformatf("sweep%0d", c), 16'h0040, 1'b1, sweep_exp[c], sweep_exp[c]);
        end
        applyStimulus(5'h00, 1'b0, 16'h0000, 5'h1F, 1'b0, 4'd14);
        checkBoth("sweep_end", 16'h0040, 1'b0, 1'b0, 1'b0);

        // Pending result and full flags, then reset mid-cycle before the next edge
        applyStimulus(5'h00, 1'b1, 16'hFFFF, 5'h1F, 1'b1, 4'd14);
        checkBoth("pre_reset", 16'h00E5, 1'b1, 1'b1, 1'b1);
        cond_req = 1'b0;
        psr_we   = 1'b0;
        #3;
        rst_n = 1'b0;
        #1;
        checkBoth("async_reset", 16'h0000, 1'b0, 1'b0, 1'b0);
        @(posedge clk);
        #4;
        rst_n = 1'b1;
        for (int k = 0; k < 3; k++) begin
            applyStimulus(5'h00, 1'b0, 16'h0000, 5'h1F, 1'b0, 4'd14);
            checkBoth($sformatf("post_reset%0d", k), 16'h0000, 1'b0, 1'b0, 1'b0);
        end

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end
endmodule
